// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the core's data-memory port. Accepts one
//               load or store per handshake, computes the effective byte
//               address, checks legality and alignment, drives the memory's
//               address / enables / byte mask / lane-replicated store data,
//               waits out read-modify-write busy on partial stores, and
//               returns sign/zero-extended load data or a fault.
// Ports       : clk_i, reset_i (async, active-high)
//               valid_i/ready_o      request handshake (ready only in IDLE)
//               is_load_i/is_store_i request type flags
//               funct3_i             RV32I width code
//               base_i/offset_i      address operands (ea = base + offset)
//               store_data_i         rs2 value
//               done_o               one-cycle completion pulse
//               result_o             formatted load data (with done_o)
//               misaligned_o/illegal_o fault flags (with done_o)
//               mem_*                data-memory port
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int width_p      = 32,
  parameter int addr_width_p = 12
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    is_load_i,
  input  logic                    is_store_i,
  input  logic [2:0]              funct3_i,
  input  logic [width_p-1:0]      base_i,
  input  logic [width_p-1:0]      offset_i,
  input  logic [width_p-1:0]      store_data_i,
  output logic                    done_o,
  output logic [width_p-1:0]      result_o,
  output logic                    misaligned_o,
  output logic                    illegal_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  output logic                    mem_read_enable_o,
  output logic                    mem_write_enable_o,
  output logic [width_p-1:0]      mem_write_data_o,
  output logic [3:0]              mem_write_mask_o,
  input  logic [width_p-1:0]      mem_read_data_i,
  input  logic                    mem_busy_i
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_REQ   = 3'd1,
    LOAD_RESP  = 3'd2,
    STORE_REQ  = 3'd3,
    STORE_WAIT = 3'd4,
    DONE       = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [width_p-1:0]      wdata_q, wdata_d;
  logic [width_p-1:0]      result_q, result_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    misaligned_q, misaligned_d;
  logic                    illegal_q, illegal_d;

  logic [width_p-1:0]      ea;
  logic [1:0]              ea_off;
  logic                    unused_ea_hi;
  logic                    req_illegal;
  logic                    req_misaligned;
  logic [3:0]              st_mask;
  logic [width_p-1:0]      st_data;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [width_p-1:0]      ld_fmt;

  // Full 32-bit sum wraps naturally; only the low address bits reach memory.
  assign ea           = base_i + offset_i;
  assign ea_off       = ea[1:0];
  assign unused_ea_hi = ^ea[width_p-1:addr_width_p];

  // Request legality and alignment. Illegal wins over misaligned.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (is_load_i == is_store_i) begin
      req_illegal = 1'b1;
    end else if (is_load_i) begin
      req_illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    end else begin
      req_illegal = funct3_i[2] || (funct3_i == 3'b011);
    end
    case (funct3_i[1:0])
      2'b01:   req_misaligned = ea_off[0];
      2'b10:   req_misaligned = |ea_off;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Store lane formatting: replicate the source across lanes, mask selects.
  always_comb begin
    st_mask = 4'b0000;
    st_data = '0;
    case (funct3_i[1:0])
      2'b00: begin
        st_mask = 4'b0001 << ea_off;
        st_data = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << ea_off;
        st_data = {2{store_data_i[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = store_data_i;
      end
    endcase
  end

  // Load formatting from the latched byte offset and width code.
  always_comb begin
    ld_byte = mem_read_data_i[7:0];
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_read_data_i[7:0];
      2'b01:   ld_byte = mem_read_data_i[15:8];
      2'b10:   ld_byte = mem_read_data_i[23:16];
      default: ld_byte = mem_read_data_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
    case (funct3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = mem_read_data_i;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    funct3_d     = funct3_q;
    result_d     = result_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          addr_d       = ea[addr_width_p-1:0];
          funct3_d     = funct3_i;
          result_d     = '0;
          illegal_d    = req_illegal;
          misaligned_d = !req_illegal && req_misaligned;
          // Mask/data only carry a real store; anything else leaves them idle.
          if (is_store_i && !req_illegal && !req_misaligned) begin
            wmask_d = st_mask;
            wdata_d = st_data;
          end else begin
            wmask_d = 4'b0000;
            wdata_d = '0;
          end
          if (req_illegal || req_misaligned) begin
            state_d = DONE;
          end else if (is_load_i) begin
            state_d = LOAD_REQ;
          end else begin
            state_d = STORE_REQ;
          end
        end
      end
      LOAD_REQ:   state_d = LOAD_RESP;
      LOAD_RESP: begin
        result_d = ld_fmt;
        state_d  = DONE;
      end
      STORE_REQ:  state_d = STORE_WAIT;
      // The first non-busy cycle here is the memory's commit cycle.
      STORE_WAIT: if (!mem_busy_i) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= 4'b0000;
      funct3_q     <= 3'b000;
      result_q     <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      funct3_q     <= funct3_d;
      result_q     <= result_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ready_o            = (state_q == IDLE);
  assign done_o             = (state_q == DONE);
  assign mem_read_enable_o  = (state_q == LOAD_REQ);
  assign mem_write_enable_o = (state_q == STORE_REQ);
  assign mem_addr_o         = addr_q;
  assign mem_write_data_o   = wdata_q;
  assign mem_write_mask_o   = wmask_q;
  assign result_o           = done_o ? result_q : '0;
  assign misaligned_o       = done_o & misaligned_q;
  assign illegal_o          = done_o & illegal_q;

endmodule
`default_nettype wire
